// File: rtl/tt_sweep_capture_pkg.sv
// tt_pkg: shared types and default sizing for the truth-table sweep/capture stage.
//   TT_N_IN_DEF   : default number of function inputs (vector count = 2**N_IN)
//   TT_SETTLE_DEF : default settle cycles held before each sample cycle
//   tt_state_e    : sequencer state encoding
package tt_pkg;

    localparam int unsigned TT_N_IN_DEF   = 4;
    localparam int unsigned TT_SETTLE_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_e;

endpackage

// File: rtl/tt_sweep_capture_if.sv
// tt_sweep_capture_if: stimulus/capture bundle between the sequencer and the
// function under test.
//   start, expected  : sweep request and expected truth table (master -> slave)
//   vec, y           : function input vector out, function output back
//   busy, done, pass : sweep status (slave -> master)
//   sig              : captured truth table
//   fail_vld/fail_idx: first-mismatch report, present only with TT_FAIL_IDX_EN
// Optional feature macro: TT_FAIL_IDX_EN
interface tt_sweep_capture_if #(
    parameter int unsigned N_IN = 4
);
    localparam int unsigned NV = 2 ** N_IN;

    logic            start;
    logic [NV-1:0]   expected;
    logic [N_IN-1:0] vec;
    logic            y;
    logic            busy;
    logic            done;
    logic            pass;
    logic [NV-1:0]   sig;
`ifdef TT_FAIL_IDX_EN
    logic            fail_vld;
    logic [N_IN-1:0] fail_idx;

    modport master (
        output start, expected, y,
        input  vec, busy, done, pass, sig, fail_vld, fail_idx
    );

    modport slave (
        input  start, expected, y,
        output vec, busy, done, pass, sig, fail_vld, fail_idx
    );
`else
    modport master (
        output start, expected, y,
        input  vec, busy, done, pass, sig
    );

    modport slave (
        input  start, expected, y,
        output vec, busy, done, pass, sig
    );
`endif

endinterface

// File: rtl/tt_sweep_capture_settle_timer.sv
// tt_settle_timer: counts cycles a vector has been held.
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : return count to zero (has priority over en)
//   en         : advance the count by one
//   tc_c       : combinational terminal count, high when count == SETTLE-1
module tt_settle_timer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc_c
);
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CW-1:0] cnt_q;

    // Count wraps harmlessly past terminal; the sequencer clears it on every sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tc_c = (cnt_q == CW'(SETTLE - 1));

endmodule

// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: sweeps the function inputs over every vector, holds each for
// SETTLE cycles, samples y on the following cycle and builds a truth-table
// signature that is compared with an expected table latched at start.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : tt_sweep_capture_if slave (start, expected, y in;
//                vec, busy, done, pass, sig [, fail_vld, fail_idx] out)
// Optional feature macro: TT_FAIL_IDX_EN adds first-mismatch index reporting.
module tt_sweep_capture
    import tt_pkg::*;
#(
    parameter int unsigned N_IN   = TT_N_IN_DEF,
    parameter int unsigned SETTLE = TT_SETTLE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    tt_sweep_capture_if.slave bus
);
    localparam int unsigned     NV       = 2 ** N_IN;
    localparam logic [N_IN-1:0] VEC_LAST = N_IN'(NV - 1);

    tt_state_e       state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [NV-1:0]   sig_q, sig_d;
    logic [NV-1:0]   exp_q, exp_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            tmr_clr_c;
    logic            tmr_en_c;
    logic            tmr_tc_c;
`ifdef TT_FAIL_IDX_EN
    logic            fail_vld_q, fail_vld_d;
    logic [N_IN-1:0] fail_idx_q, fail_idx_d;
`endif

    // Hold-time counter for the current vector.
    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr_c),
        .en    (tmr_en_c),
        .tc_c  (tmr_tc_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            sig_q      <= '0;
            exp_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
`ifdef TT_FAIL_IDX_EN
            fail_vld_q <= 1'b0;
            fail_idx_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            sig_q      <= sig_d;
            exp_q      <= exp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
`ifdef TT_FAIL_IDX_EN
            fail_vld_q <= fail_vld_d;
            fail_idx_q <= fail_idx_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        sig_d      = sig_q;
        exp_d      = exp_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        tmr_clr_c  = 1'b0;
        tmr_en_c   = 1'b0;
`ifdef TT_FAIL_IDX_EN
        fail_vld_d = fail_vld_q;
        fail_idx_d = fail_idx_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    exp_d      = bus.expected;
                    vec_d      = '0;
                    sig_d      = '0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                    tmr_clr_c  = 1'b1;
`ifdef TT_FAIL_IDX_EN
                    fail_vld_d = 1'b0;
                    fail_idx_d = '0;
`endif
                    state_d    = tt_pkg::SETTLE;
                end
            end

            tt_pkg::SETTLE: begin
                tmr_en_c = 1'b1;
                if (tmr_tc_c) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                sig_d[vec_q] = bus.y;
`ifdef TT_FAIL_IDX_EN
                // Only the first mismatch of a sweep is reported.
                if ((bus.y != exp_q[vec_q]) && !fail_vld_q) begin
                    fail_vld_d = 1'b1;
                    fail_idx_d = vec_q;
                end
`endif
                if (vec_q == VEC_LAST) begin
                    // Compare includes the sample taken on this edge.
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (sig_d == exp_q);
                    state_d = DONE;
                end else begin
                    vec_d     = vec_q + N_IN'(1);
                    tmr_clr_c = 1'b1;
                    state_d   = tt_pkg::SETTLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.vec  = vec_q;
    assign bus.sig  = sig_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.pass = pass_q;
`ifdef TT_FAIL_IDX_EN
    assign bus.fail_vld = fail_vld_q;
    assign bus.fail_idx = fail_idx_q;
`endif

endmodule
